// File: rtl/l2_cache_nway.sv
// l2_cache_nway: N-way set-associative, write-back, write-allocate L2 cache.
// Controller FSM (IDLE/COMPARE/WRITEBACK/FILL), tree pseudo-LRU replacement,
// lowest-invalid-first victim selection. Full-line transfers, 16-bit addresses.
// Optional feature macro: L2_STATS_EN adds saturating hit/miss/writeback counters.
module l2_cache_nway #(
    parameter int WAYS     = 4,
    parameter int SETS     = 32,
    parameter int LINESIZE = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         mem_address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [LINESIZE-1:0] mem_wdata,
    output logic [LINESIZE-1:0] mem_rdata,
    output logic                mem_resp,
    output logic [15:0]         pmem_address,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [LINESIZE-1:0] pmem_wdata,
    input  logic [LINESIZE-1:0] pmem_rdata,
    input  logic                pmem_resp
`ifdef L2_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         wb_count
`endif
);

    localparam int OFF = $clog2(LINESIZE / 8);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 16 - IDX - OFF;
    localparam int LG  = $clog2(WAYS);
    localparam int NP  = WAYS - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_WB      = 2'd2;
    localparam logic [1:0] S_FILL    = 2'd3;

    // Storage: tags and data are never reset; valid/dirty gate their use.
    logic [TAG-1:0]      tag_q   [WAYS][SETS];
    logic [LINESIZE-1:0] data_q  [WAYS][SETS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [NP-1:0]       plru_q  [SETS];

    logic [1:0]          state_q, state_d;
    logic [TAG+IDX-1:0]  line_q;      // tag+index of the request being served
    logic                write_q;     // request is a write (write wins over read)
    logic [LG-1:0]       victim_q;    // way chosen on a miss, held for the whole miss
    logic [15:0]         pmem_addr_q;

    logic [TAG-1:0]      req_tag;
    logic [IDX-1:0]      req_idx;
    logic                req_active;
    logic                hit;
    logic [LG-1:0]       hit_way;
    logic                inv_found;
    logic [LG-1:0]       inv_way;
    logic [LG-1:0]       victim_sel;
    logic                victim_dirty;

    // Offset bits only select bytes within a line, which this cache never does.
    logic unused_offset;
    assign unused_offset = ^mem_address[OFF-1:0];

    assign req_tag    = line_q[TAG+IDX-1:IDX];
    assign req_idx    = line_q[IDX-1:0];
    assign req_active = mem_read | mem_write;

    // Walk the tree from the root following the LRU-direction bits.
    // Bit value 0 means the left subtree holds the LRU way, 1 the right one.
    function automatic logic [LG-1:0] plru_victim(input logic [NP-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < LG; l++) node = 2 * node + int'(bits[node-1]);
        return LG'(node - WAYS);
    endfunction

    // Make every node on the path to the accessed way point to the other side.
    function automatic logic [NP-1:0] plru_touch(input logic [NP-1:0] bits,
                                                 input logic [LG-1:0] way);
        logic [NP-1:0] nb;
        int node;
        nb   = bits;
        node = 1;
        for (int l = 0; l < LG; l++) begin
            nb[node-1] = ~way[LG-1-l];
            node       = 2 * node + int'(way[LG-1-l]);
        end
        return nb;
    endfunction

    // Tag compare across all ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = LG'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the pseudo-LRU way.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = LG'(w);
            end
        end
        victim_sel   = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
        victim_dirty = valid_q[req_idx][victim_sel] & dirty_q[req_idx][victim_sel];
    end

    // Next-state logic of the controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req_active) state_d = S_COMPARE;
            S_COMPARE: begin
                if (!req_active || hit) state_d = S_IDLE;
                else if (victim_dirty)  state_d = S_WB;
                else                    state_d = S_FILL;
            end
            S_WB:      if (pmem_resp) state_d = S_FILL;
            S_FILL:    if (pmem_resp) state_d = S_COMPARE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Controller state, metadata (valid/dirty/PLRU) and pmem address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            line_q      <= '0;
            write_q     <= 1'b0;
            victim_q    <= '0;
            pmem_addr_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_active) begin
                        line_q  <= mem_address[15:OFF];
                        write_q <= mem_write;
                    end
                end
                S_COMPARE: begin
                    if (req_active && hit) begin
                        plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                        if (write_q) dirty_q[req_idx][hit_way] <= 1'b1;
                    end else if (req_active) begin
                        victim_q <= victim_sel;
                        if (victim_dirty)
                            pmem_addr_q <= {tag_q[victim_sel][req_idx], req_idx, {OFF{1'b0}}};
                        else
                            pmem_addr_q <= {req_tag, req_idx, {OFF{1'b0}}};
                    end
                end
                S_WB: begin
                    if (pmem_resp) pmem_addr_q <= {req_tag, req_idx, {OFF{1'b0}}};
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        valid_q[req_idx][victim_q] <= 1'b1;
                        dirty_q[req_idx][victim_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: written on write hits and on fill completion.
    always_ff @(posedge clk) begin
        if (state_q == S_COMPARE && req_active && hit && write_q)
            data_q[hit_way][req_idx] <= mem_wdata;
        if (state_q == S_FILL && pmem_resp) begin
            data_q[victim_q][req_idx] <= pmem_rdata;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end

    assign mem_resp     = (state_q == S_COMPARE) && req_active && hit;
    assign mem_rdata    = data_q[hit_way][req_idx];
    assign pmem_read    = (state_q == S_FILL);
    assign pmem_write   = (state_q == S_WB);
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = data_q[victim_q][req_idx];

`ifdef L2_STATS_EN
    logic        first_q;  // first COMPARE of the current request
    logic [31:0] hit_q, miss_q, wb_q;

    // Hit/miss counted once per request at its first COMPARE; writebacks on completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
        end else begin
            if (state_q == S_IDLE && req_active) first_q <= 1'b1;
            else if (state_q == S_COMPARE)       first_q <= 1'b0;
            if (state_q == S_COMPARE && first_q && req_active) begin
                if (hit) begin
                    if (hit_q != '1) hit_q <= hit_q + 32'd1;
                end else begin
                    if (miss_q != '1) miss_q <= miss_q + 32'd1;
                end
            end
            if (state_q == S_WB && pmem_resp && wb_q != '1) wb_q <= wb_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`endif

endmodule
